// File: rtl/display_scheduler.sv
// Time-shares one 4-digit hex display between four 16-bit sources,
// with a preempting alert channel and a manual pin-to-source mode.
module display_scheduler #(
  parameter int TICK_DIV    = 100000,
  parameter int DWELL_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] src_data,
  input  logic [3:0]  src_req,
  input  logic        manual_en,
  input  logic [1:0]  manual_sel,
  input  logic        alert_req,
  input  logic [15:0] alert_data,
  output logic [15:0] digits,
  output logic [1:0]  ones_place,
  output logic        enable_dp,
  output logic [3:0]  grant,
  output logic [1:0]  active_src,
  output logic [3:0]  done,
  output logic        alert_ack
);

  localparam int PW =
    (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int DW =
    (DWELL_TICKS > 2) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DWELL_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    ALERT,
    MANUAL
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  active_q, active_d;
  logic [1:0]  ones_q, ones_d;
  logic        dp_q, dp_d;
  logic [3:0]  done_q, done_d;
  logic        ack_q, ack_d;
  logic [1:0]  rr_q, rr_d;
  logic [1:0]  saved_q, saved_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic       tick;
  logic       expiry;
  logic       found;
  logic [1:0] sel;
  logic       count;
  logic       to_alert;
  logic       to_manual;
  logic       to_idle;

  function automatic logic [15:0] word(
    input logic [63:0] d,
    input logic [1:0]  i
  );
    return d[{i, 4'b0000} +: 16];
  endfunction

  assign tick   = (presc_q == PMAX);
  assign expiry = tick && (dwell_q == DMAX);

  // Scan rr+1, rr+2, ... so the last owner is considered last.
  always_comb begin
    logic [1:0] cand;
    cand  = '0;
    found = 1'b0;
    sel   = rr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = rr_q + 2'(k);
      if (!found && src_req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    grant_d   = grant_q;
    active_d  = active_q;
    ones_d    = ones_q;
    dp_d      = dp_q;
    done_d    = '0;
    ack_d     = 1'b0;
    rr_d      = rr_q;
    saved_d   = saved_q;
    presc_d   = '0;
    dwell_d   = '0;
    count     = 1'b0;
    to_alert  = 1'b0;
    to_manual = 1'b0;
    to_idle   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (alert_req) begin
          to_alert = 1'b1;
        end else if (manual_en) begin
          to_manual = 1'b1;
        end else if (found) begin
          state_d  = SHOW;
          grant_d  = 4'b0001 << sel;
          active_d = sel;
          ones_d   = sel;
          dp_d     = 1'b1;
          digits_d = word(src_data, sel);
          saved_d  = rr_q;
          rr_d     = sel;
        end else begin
          to_idle = 1'b1;
        end
      end
      SHOW: begin
        if (alert_req) begin
          to_alert = 1'b1;
          if (expiry) done_d[active_q] = 1'b1;
          else        rr_d = saved_q;
        end else if (manual_en) begin
          to_manual = 1'b1;
        end else if (expiry) begin
          to_idle          = 1'b1;
          done_d[active_q] = 1'b1;
        end else if (!src_req[active_q]) begin
          to_idle = 1'b1;
        end else begin
          digits_d = word(src_data, active_q);
          count    = 1'b1;
        end
      end
      ALERT: begin
        if (!alert_req || expiry) begin
          ack_d = alert_req && expiry;
          if (manual_en) to_manual = 1'b1;
          else           to_idle   = 1'b1;
        end else begin
          digits_d = alert_data;
          count    = 1'b1;
        end
      end
      MANUAL: begin
        if (alert_req)      to_alert  = 1'b1;
        else if (manual_en) to_manual = 1'b1;
        else                to_idle   = 1'b1;
      end
      default: to_idle = 1'b1;
    endcase

    if (count) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      dwell_d = tick ? dwell_q + 1'b1 : dwell_q;
    end

    if (to_alert) begin
      state_d  = ALERT;
      grant_d  = '0;
      dp_d     = 1'b0;
      digits_d = alert_data;
    end
    if (to_manual) begin
      state_d  = MANUAL;
      grant_d  = '0;
      active_d = manual_sel;
      ones_d   = manual_sel;
      dp_d     = 1'b1;
      digits_d = word(src_data, manual_sel);
    end
    if (to_idle) begin
      state_d = IDLE;
      grant_d = '0;
      dp_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      digits_q <= '0;
      grant_q  <= '0;
      active_q <= '0;
      ones_q   <= '0;
      dp_q     <= 1'b0;
      done_q   <= '0;
      ack_q    <= 1'b0;
      rr_q     <= 2'd3;
      saved_q  <= 2'd3;
      presc_q  <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      grant_q  <= grant_d;
      active_q <= active_d;
      ones_q   <= ones_d;
      dp_q     <= dp_d;
      done_q   <= done_d;
      ack_q    <= ack_d;
      rr_q     <= rr_d;
      saved_q  <= saved_d;
      presc_q  <= presc_d;
      dwell_q  <= dwell_d;
    end
  end

  assign digits     = digits_q;
  assign ones_place = ones_q;
  assign enable_dp  = dp_q;
  assign grant      = grant_q;
  assign active_src = active_q;
  assign done       = done_q;
  assign alert_ack  = ack_q;

endmodule
